mem_responder: RTL and testbench
================================

# mem_responder

Memory-side responder for the processor's memory handshake. It accepts read and write requests from the control signal generator and the datapath (MEM_Read, MEM_Write, address from MuxMA, store data from RM), and services them against an internal word array after a programmable wait. It completes each transfer with MEM_MFC, and flags unmapped or illegal accesses with MEM_ANA_FLAG. It sits outside the datapath as the RAM1 model/controller for the Memory stage.

## Interface
- ADDR_BASE, 32'h0000_0000, byte address of word 0
- DEPTH_WORDS, 256, number of 32-bit words; power of two, 2..4096
- LATENCY, 2, wait cycles from request capture to completion; 0..15
- Clock  in  1  rising-edge clock
- Reset_n  in  1  asynchronous, active-low reset
- MEM_Read  in  1  read request, level; held until MEM_MFC
- MEM_Write  in  1  write request, level; held until MEM_MFC
- MEM_Address  in  32  byte address; held stable while a request is high
- MEM_DataIn  in  32  store data; held stable while MEM_Write is high
- MEM_DataOut  out  32  registered load data
- MEM_MFC  out  1  memory function complete, registered
- MEM_ANA_FLAG  out  1  address not assigned / illegal request, registered; valid only while MEM_MFC=1

One clock; reset is asynchronous and active-low.

## Operation
- States: IDLE, WAIT, DONE. Reset forces IDLE.
- Reset values: MEM_DataOut=0, MEM_MFC=0, MEM_ANA_FLAG=0, counter=0.
- Word array contents are not reset.
- IDLE, (MEM_Read|MEM_Write)=1 at an edge (capture edge E0):
  - Latch op, address and data.
  - Go to DONE if LATENCY=0; otherwise go to WAIT with counter=LATENCY.
- WAIT: decrement the counter each edge. On the edge where the counter is 1, perform the access and go to DONE.
- Access is performed on the DONE-entry edge:
  - mapped = (addr >= ADDR_BASE) && ((addr-ADDR_BASE)>>2 < DEPTH_WORDS) && addr[1:0]==0. The subtraction is 32-bit unsigned, and the range check uses no wrap-around.
  - Read, mapped: MEM_DataOut ← array[index], ANA=0.
  - Write, mapped: array[index] ← latched data; MEM_DataOut unchanged; ANA=0.
  - Unmapped read: MEM_DataOut ← 0, ANA=1.
  - Unmapped write: array unchanged, ANA=1.
  - Read and Write both high at capture: illegal. No array write, MEM_DataOut unchanged, ANA=1.
- DONE: MEM_MFC=1 and ANA holds. On the first edge with MEM_Read=0 and MEM_Write=0, go to IDLE and clear MFC and ANA.
- Requests are sampled only in IDLE. Inputs changing during WAIT or DONE are ignored, because the latched values are used.
- Request dropped during WAIT (protocol violation): the access still completes; DONE exits on the next edge, so MFC is a 1-cycle pulse.
- MEM_DataOut holds its value until the next completed read, including across writes and idle time.
- Reset mid-operation: return to IDLE immediately with MFC=0, ANA=0 and DataOut=0. A write not yet at its DONE-entry edge is not performed. A request still high after reset release is captured as a new request.

## Timing
- MEM_MFC rises on edge E0+LATENCY. For LATENCY=0 it rises on E0 itself.
- The load data is valid on MEM_DataOut from the same edge MFC rises.
- MFC falls on the first edge after both requests are observed low. The minimum DONE residence is 1 cycle.
- Back-to-back: a new request is captured no earlier than the edge after the return to IDLE. The minimum period per transfer is LATENCY+2 cycles.
- The write commit is visible to a read captured at any later IDLE.
- All outputs are direct register outputs, with no combinational path from any input.

## Test plan
- Reset, then LATENCY=2, write 32'hDEAD_BEEF to 0x0000_0010 captured at E0, request dropped on MFC, then read 0x10.
  - Write: MFC high at E0+2, low one edge after MEM_Write falls, ANA=0.
  - Read: DataOut=32'hDEAD_BEEF with MFC, ANA=0.
- Read 0x0000_0400 with DEPTH_WORDS=256 (index 256), then read 0x0000_0013 (misaligned).
  - Both: MFC asserted, ANA=1, DataOut=0.
  - Neither access changes the array.
- MEM_Read and MEM_Write both high, addr 0x8, data 32'h1234_5678; then read 0x8.
  - First access: MFC with ANA=1.
  - Subsequent read returns the prior contents of 0x8, not 32'h1234_5678.
- LATENCY=0, read held for 3 cycles after MFC.
  - MFC rises on the capture edge and stays high all 3 cycles.
  - MFC falls one edge after the read drops.
  - Next capture occurs no earlier than the edge after that.
- Write to 0x20 with LATENCY=4; assert Reset_n=0 asynchronously at E0+2; release; read 0x20.
  - Asynchronous reset: MFC, ANA and DataOut go to 0 immediately, without waiting for a clock edge.
  - The read returns the pre-write contents of 0x20.
- Read request dropped at E0+1 during WAIT (LATENCY=3).
  - MFC is a single-cycle pulse at E0+3.
  - DataOut is updated with the read data.

Source files
------------

// File: rtl/mem_responder_if.sv
// Memory handshake bus between the requester (control/datapath) and the
// memory responder. The requester drives the request side and the responder
// drives completion, status and load data.
interface mem_responder_if;
   logic        MEM_Read;
   logic        MEM_Write;
   logic [31:0] MEM_Address;
   logic [31:0] MEM_DataIn;
   logic [31:0] MEM_DataOut;
   logic        MEM_MFC;
   logic        MEM_ANA_FLAG;

   modport master (
      output MEM_Read, MEM_Write, MEM_Address, MEM_DataIn,
      input  MEM_DataOut, MEM_MFC, MEM_ANA_FLAG
   );

   modport slave (
      input  MEM_Read, MEM_Write, MEM_Address, MEM_DataIn,
      output MEM_DataOut, MEM_MFC, MEM_ANA_FLAG
   );
endinterface

// File: rtl/mem_responder.sv
// RAM model/controller for the Memory stage. Captures a read or write in
// IDLE, waits LATENCY cycles, performs the access against an internal word
// array and completes with MEM_MFC. Unmapped, misaligned or read+write
// requests complete with MEM_ANA_FLAG set.
module mem_responder #(
   parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
   parameter int          DEPTH_WORDS = 256,
   parameter int          LATENCY     = 2
) (
   input  logic          Clock,
   input  logic          Reset_n,
   mem_responder_if.slave bus
);

   localparam int         IDXW = $clog2(DEPTH_WORDS);
   localparam logic [3:0] LAT  = 4'(LATENCY);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

   state_t           r_state, w_state_nxt;
   logic [3:0]       r_cnt;
   logic             r_rd, r_wr;
   logic [31:0]      r_addr, r_data;
   logic [31:0]      r_dout;
   logic             r_mfc, r_ana;
   logic [31:0]      r_mem [DEPTH_WORDS];

   logic             w_req, w_cap, w_access;
   logic             w_rd, w_wr;
   logic [31:0]      w_addr, w_data, w_off;
   logic             w_mapped;
   logic [IDXW-1:0]  w_idx;
   logic             w_mfc_nxt, w_ana_nxt, w_we;
   logic [31:0]      w_dout_nxt;

   assign w_req = bus.MEM_Read | bus.MEM_Write;
   assign w_cap = (r_state == S_IDLE) && w_req;

   // The DONE-entry edge is either the capture edge itself (zero latency)
   // or the last WAIT edge. Reset gates it so the unreset array is never
   // written while the block is held in reset.
   assign w_access = Reset_n && ((w_cap && (LAT == 4'd0)) ||
                                 ((r_state == S_WAIT) && (r_cnt == 4'd1)));

   // On the zero-latency path the access uses the live bus, otherwise the
   // values latched at capture.
   assign w_rd   = w_cap ? bus.MEM_Read    : r_rd;
   assign w_wr   = w_cap ? bus.MEM_Write   : r_wr;
   assign w_addr = w_cap ? bus.MEM_Address : r_addr;
   assign w_data = w_cap ? bus.MEM_DataIn  : r_data;

   // No wrap-around: an address below the base is unmapped before the
   // subtraction result is even considered.
   assign w_off    = w_addr - ADDR_BASE;
   assign w_mapped = (w_addr >= ADDR_BASE) &&
                     ((w_off >> 2) < 32'(DEPTH_WORDS)) &&
                     (w_addr[1:0] == 2'b00);
   assign w_idx    = w_off[IDXW+1:2];

   // State register plus request latch and wait counter.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
         r_rd    <= 1'b0;
         r_wr    <= 1'b0;
         r_addr  <= 32'd0;
         r_data  <= 32'd0;
      end else begin
         r_state <= w_state_nxt;
         if (w_cap) begin
            r_rd   <= bus.MEM_Read;
            r_wr   <= bus.MEM_Write;
            r_addr <= bus.MEM_Address;
            r_data <= bus.MEM_DataIn;
            r_cnt  <= LAT;
         end else if (r_state == S_WAIT) begin
            r_cnt  <= r_cnt - 4'd1;
         end
      end
   end

   // Next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_req) w_state_nxt = (LAT == 4'd0) ? S_DONE : S_WAIT;
         S_WAIT:  if (r_cnt == 4'd1) w_state_nxt = S_DONE;
         S_DONE:  if (!w_req) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Next values of the registered outputs and the array write enable.
   always_comb begin
      w_mfc_nxt  = r_mfc;
      w_ana_nxt  = r_ana;
      w_dout_nxt = r_dout;
      w_we       = 1'b0;
      if (w_access) begin
         w_mfc_nxt = 1'b1;
         if (w_rd && w_wr) begin
            w_ana_nxt = 1'b1;
         end else if (!w_mapped) begin
            w_ana_nxt = 1'b1;
            if (w_rd) w_dout_nxt = 32'd0;
         end else begin
            w_ana_nxt = 1'b0;
            if (w_rd) w_dout_nxt = r_mem[w_idx];
            else      w_we       = 1'b1;
         end
      end else if ((r_state == S_DONE) && !w_req) begin
         w_mfc_nxt = 1'b0;
         w_ana_nxt = 1'b0;
      end
   end

   // Output registers: no combinational path from the bus to any output.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         r_mfc  <= 1'b0;
         r_ana  <= 1'b0;
         r_dout <= 32'd0;
      end else begin
         r_mfc  <= w_mfc_nxt;
         r_ana  <= w_ana_nxt;
         r_dout <= w_dout_nxt;
      end
   end

   // Word array, intentionally not reset.
   always_ff @(posedge Clock) begin
      if (w_we) r_mem[w_idx] <= w_data;
   end

   assign bus.MEM_MFC      = r_mfc;
   assign bus.MEM_ANA_FLAG = r_ana;
   assign bus.MEM_DataOut  = r_dout;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: four instances at latencies 0/2/3/4 share one
// clock and reset. Table vectors, a randomized run against a word-level
// model, and hand sequences for the multi-cycle corner cases.
module tb_mem_responder;

   localparam int LATS [4] = '{0, 2, 3, 4};
   localparam logic [31:0] BASE  = 32'h0;
   localparam int          DEPTH = 256;

   logic        clk, rst_n;
   logic        rd   [4];
   logic        wr   [4];
   logic [31:0] addr [4];
   logic [31:0] din  [4];
   logic        mfc  [4];
   logic        ana  [4];
   logic [31:0] dout [4];

   int n_tests = 0;
   int n_fail  = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      mem_responder_if u_if ();
      assign u_if.MEM_Read    = rd[g];
      assign u_if.MEM_Write   = wr[g];
      assign u_if.MEM_Address = addr[g];
      assign u_if.MEM_DataIn  = din[g];
      assign mfc[g]  = u_if.MEM_MFC;
      assign ana[g]  = u_if.MEM_ANA_FLAG;
      assign dout[g] = u_if.MEM_DataOut;
      mem_responder #(.ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(LATS[g]))
         u_dut (.Clock(clk), .Reset_n(rst_n), .bus(u_if.slave));
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   // One full transfer: drive, wait for MFC (bounded), record, drop, check fall.
   task automatic xfer(input int k, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] d,
                       output logic o_ana, output logic [31:0] o_dout);
      int n;
      bit seen;
      @(negedge clk);
      rd[k] = r; wr[k] = w; addr[k] = a; din[k] = d;
      n = 0; seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(posedge clk); #1;
         if (mfc[k]) seen = 1'b1;
         else        n++;
      end
      chk($sformatf("inst%0d_mfc_seen", k), 32'(seen), 32'd1);
      chk($sformatf("inst%0d_latency", k), 32'(n), 32'(LATS[k]));
      o_ana  = ana[k];
      o_dout = dout[k];
      rd[k] = 1'b0; wr[k] = 1'b0;
      @(posedge clk); #1;
      chk($sformatf("inst%0d_mfc_fall", k), 32'(mfc[k]), 32'd0);
      chk($sformatf("inst%0d_ana_clear", k), 32'(ana[k]), 32'd0);
   endtask

   function automatic bit is_mapped(input logic [31:0] a);
      longint unsigned ua, ub;
      ua = longint'(a);
      ub = longint'(BASE);
      return (ua >= ub) && ((ua - ub) / 4 < DEPTH) && (ua % 4 == 0);
   endfunction

   typedef struct {
      logic        r, w;
      logic [31:0] a, d;
      logic        ana;
      logic [31:0] dout;
   } vec_t;

   vec_t        tbl [12];
   logic        g_ana;
   logic [31:0] g_dout;
   logic [31:0] m_mem [16];
   logic [31:0] m_dout;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000};
      tbl[1]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
      tbl[2]  = '{1'b1, 1'b0, 32'h0000_0400, 32'h0,         1'b1, 32'h0000_0000};
      tbl[3]  = '{1'b1, 1'b0, 32'h0000_0013, 32'h0,         1'b1, 32'h0000_0000};
      tbl[4]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
      tbl[5]  = '{1'b0, 1'b1, 32'h0000_0008, 32'h0000_0001, 1'b0, 32'hDEAD_BEEF};
      tbl[6]  = '{1'b1, 1'b1, 32'h0000_0008, 32'h1234_5678, 1'b1, 32'hDEAD_BEEF};
      tbl[7]  = '{1'b1, 1'b0, 32'h0000_0008, 32'h0,         1'b0, 32'h0000_0001};
      tbl[8]  = '{1'b0, 1'b1, 32'h0000_0400, 32'hFFFF_FFFF, 1'b1, 32'h0000_0001};
      tbl[9]  = '{1'b0, 1'b1, 32'h0000_000E, 32'h7777_7777, 1'b1, 32'h0000_0001};
      tbl[10] = '{1'b0, 1'b1, 32'h0000_03FC, 32'hA5A5_A5A5, 1'b0, 32'h0000_0001};
      tbl[11] = '{1'b1, 1'b0, 32'h0000_03FC, 32'h0,         1'b0, 32'hA5A5_A5A5};

      rst_n = 1'b0;
      for (int k = 0; k < 4; k++) begin
         rd[k] = 1'b0; wr[k] = 1'b0; addr[k] = 32'd0; din[k] = 32'd0;
      end
      #23;
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("reset_mfc%0d", k),  32'(mfc[k]), 32'd0);
         chk($sformatf("reset_ana%0d", k),  32'(ana[k]), 32'd0);
         chk($sformatf("reset_dout%0d", k), dout[k], 32'd0);
      end
      @(negedge clk); rst_n = 1'b1;

      // Table vectors on the LATENCY=2 instance.
      for (int i = 0; i < 12; i++) begin
         xfer(1, tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d, g_ana, g_dout);
         chk($sformatf("tbl%0d_ana", i),  32'(g_ana), 32'(tbl[i].ana));
         chk($sformatf("tbl%0d_dout", i), g_dout, tbl[i].dout);
      end

      // Randomized run against a word-level model over words 0..15.
      m_dout = 32'hA5A5_A5A5;
      for (int i = 0; i < 16; i++) begin
         m_mem[i] = $urandom;
         xfer(1, 1'b0, 1'b1, 32'(i * 4), m_mem[i], g_ana, g_dout);
      end
      for (int t = 0; t < 40; t++) begin
         int op, kind, idx;
         logic r, w, e_ana;
         logic [31:0] a, d;
         op = int'($urandom_range(0, 3));
         kind = int'($urandom_range(0, 3));
         idx = int'($urandom_range(0, 15));
         r = (op != 2);
         w = (op >= 2);
         d = $urandom;
         if (kind <= 1)      a = 32'(idx * 4);
         else if (kind == 2) a = 32'($urandom_range(256, 1000) * 4);
         else                a = 32'(idx * 4 + int'($urandom_range(1, 3)));
         if (r && w) begin
            e_ana = 1'b1;
         end else if (!is_mapped(a)) begin
            e_ana = 1'b1;
            if (r) m_dout = 32'd0;
         end else begin
            e_ana = 1'b0;
            if (r) m_dout = m_mem[a / 4];
            else   m_mem[a / 4] = d;
         end
         xfer(1, r, w, a, d, g_ana, g_dout);
         chk($sformatf("rnd%0d_ana", t),  32'(g_ana), 32'(e_ana));
         chk($sformatf("rnd%0d_dout", t), g_dout, m_dout);
      end

      // LATENCY=0: MFC on the capture edge, held while the read is held.
      xfer(0, 1'b0, 1'b1, 32'h40, 32'h0BAD_F00D, g_ana, g_dout);
      @(negedge clk);
      rd[0] = 1'b1; addr[0] = 32'h40;
      @(posedge clk); #1;
      chk("l0_mfc_capture", 32'(mfc[0]), 32'd1);
      chk("l0_dout", dout[0], 32'h0BAD_F00D);
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         chk($sformatf("l0_mfc_hold%0d", c), 32'(mfc[0]), 32'd1);
      end
      rd[0] = 1'b0;
      @(posedge clk); #1;
      chk("l0_mfc_fall", 32'(mfc[0]), 32'd0);
      rd[0] = 1'b1;
      #1;
      chk("l0_no_comb_path", 32'(mfc[0]), 32'd0);
      @(posedge clk); #1;
      chk("l0_recapture", 32'(mfc[0]), 32'd1);
      rd[0] = 1'b0;
      @(posedge clk); #1;
      chk("l0_mfc_fall2", 32'(mfc[0]), 32'd0);

      // LATENCY=3: read dropped during WAIT still completes as a 1-cycle pulse.
      xfer(2, 1'b0, 1'b1, 32'h30, 32'hCAFE_F00D, g_ana, g_dout);
      @(negedge clk);
      rd[2] = 1'b1; addr[2] = 32'h30;
      @(posedge clk);
      @(posedge clk); #1;
      rd[2] = 1'b0;
      chk("drop_mfc_e1", 32'(mfc[2]), 32'd0);
      @(posedge clk); #1;
      chk("drop_mfc_e2", 32'(mfc[2]), 32'd0);
      @(posedge clk); #1;
      chk("drop_mfc_e3", 32'(mfc[2]), 32'd1);
      chk("drop_dout", dout[2], 32'hCAFE_F00D);
      @(posedge clk); #1;
      chk("drop_mfc_pulse_end", 32'(mfc[2]), 32'd0);

      // LATENCY=4: asynchronous reset aborts a pending write.
      xfer(3, 1'b0, 1'b1, 32'h20, 32'hAAAA_0000, g_ana, g_dout);
      xfer(3, 1'b1, 1'b0, 32'h20, 32'h0, g_ana, g_dout);
      chk("rst_pre_dout", g_dout, 32'hAAAA_0000);
      @(negedge clk);
      wr[3] = 1'b1; addr[3] = 32'h20; din[3] = 32'h5555_5555;
      @(posedge clk);
      @(posedge clk);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("arst_mfc",  32'(mfc[3]), 32'd0);
      chk("arst_ana",  32'(ana[3]), 32'd0);
      chk("arst_dout", dout[3], 32'd0);
      wr[3] = 1'b0;
      @(negedge clk);
      @(negedge clk); rst_n = 1'b1;
      xfer(3, 1'b1, 1'b0, 32'h20, 32'h0, g_ana, g_dout);
      chk("arst_read_ana",  32'(g_ana), 32'd0);
      chk("arst_read_dout", g_dout, 32'hAAAA_0000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
